// File: rtl/counter_arbiter.sv
// Two-requester arbiter for a shared up/down/load counter.
// A grant lasts until the owner drops its request or BURST cycles elapse, then one dead GAP
// cycle follows before the next grant. Ties go to the requester not recorded in r_last.
module counter_arbiter #(
  parameter int unsigned BURST = 4
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       req0,
  input  logic [1:0] MODO0,
  input  logic [3:0] D0,
  input  logic       req1,
  input  logic [1:0] MODO1,
  input  logic [3:0] D1,
  input  logic       cnt_RCO,
  output logic       ENABLE,
  output logic [1:0] MODO,
  output logic [3:0] D,
  output logic       gnt0,
  output logic       gnt1,
  output logic       rco0,
  output logic       rco1
);

  localparam logic [3:0] BurstMax = 4'(BURST);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1, StGap} state_e;

  state_e     r_state, w_state_next;
  logic [3:0] r_burst, w_burst_next;
  logic       r_last, w_last_next;

  // State, burst counter and last-owner pointer; r_last=1 lets requester 0 win the first tie.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      r_state <= StIdle;
      r_burst <= 4'd0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_burst <= w_burst_next;
      r_last  <= w_last_next;
    end
  end

  // Next-state: arbitrate in IDLE/GAP, count the burst while owned, leave through GAP.
  always_comb begin
    w_state_next = r_state;
    w_burst_next = r_burst;
    w_last_next  = r_last;
    unique case (r_state)
      StIdle, StGap: begin
        w_burst_next = 4'd0;
        if (req0 && (!req1 || r_last)) begin
          w_state_next = StOwn0;
          w_last_next  = 1'b0;
          w_burst_next = 4'd1;
        end else if (req1) begin
          w_state_next = StOwn1;
          w_last_next  = 1'b1;
          w_burst_next = 4'd1;
        end else begin
          w_state_next = StIdle;
        end
      end
      StOwn0: begin
        if (!req0 || (r_burst == BurstMax)) begin
          w_state_next = StGap;
          w_burst_next = 4'd0;
        end else begin
          w_burst_next = r_burst + 4'd1;
        end
      end
      StOwn1: begin
        if (!req1 || (r_burst == BurstMax)) begin
          w_state_next = StGap;
          w_burst_next = 4'd0;
        end else begin
          w_burst_next = r_burst + 4'd1;
        end
      end
      default: begin
        w_state_next = StIdle;
        w_burst_next = 4'd0;
      end
    endcase
  end

  // Outputs: grants decode registered state; the owner's mode/data pass straight through.
  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    ENABLE = 1'b0;
    MODO   = 2'b00;
    D      = 4'h0;
    unique case (r_state)
      StOwn0: begin
        gnt0   = 1'b1;
        ENABLE = req0;
        MODO   = MODO0;
        D      = D0;
      end
      StOwn1: begin
        gnt1   = 1'b1;
        ENABLE = req1;
        MODO   = MODO1;
        D      = D1;
      end
      default: begin
        gnt0 = 1'b0;
      end
    endcase
  end

  // Ripple carry is visible only to the current owner.
  always_comb begin
    rco0 = cnt_RCO & gnt0;
    rco1 = cnt_RCO & gnt1;
  end

endmodule
